// File: rtl/seg7_pkg.sv
// Shared constants for the 74HC595 seven-segment scan driver.
// Holds the active-low glyph table, BCD digit payload type and FSM encoding.
package seg7_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned NUM_DIGITS = 4;

  // Active-low segment patterns: bit0=a .. bit6=g, bit7=dp (kept off).
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_C     = 8'hC6;

  // Entry [n] is the glyph for decimal digit n.
  localparam logic [9:0][7:0] GLYPH_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  // One-hot digit select byte for the second 595.
  function automatic logic [7:0] digit_select(input logic [1:0] idx);
    return 8'(8'h01 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: bcd (4-bit digit), blank (force all segments off),
//        seg_c (8-bit active-low pattern, dp off).
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg_c
);

  // Blank wins; any non-decimal code shows a dash.
  always_comb begin
    if (blank) begin
      seg_c = GLYPH_BLANK;
    end else if (bcd > 4'd9) begin
      seg_c = GLYPH_DASH;
    end else begin
      seg_c = GLYPH_DIGITS[bcd];
    end
  end

endmodule

// File: rtl/seg595_scan_driver.sv
// Multiplexed 4-digit display driver through two chained 74HC595s.
// Per digit: LOAD (1 cycle), SHIFT 16 bits MSB first, LATCH, HOLD.
// Ports: clk, rst (sync, active-high), en (scan enable), upd (capture strobe),
//        hundreds/tens/ones (BCD in), sclk/rclk/dio (595 serial interface),
//        busy (not idle), frame_done (pulse in last HOLD cycle of digit 3).
module seg595_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned HOLD_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       upd,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       sclk,
  output logic       rclk,
  output logic       dio,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd15;

  state_e              state, state_n;
  logic [1:0]          idx, idx_n;
  logic [DIV_W-1:0]    div_cnt, div_n;
  logic [3:0]          bit_cnt, bit_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [WORD_W-1:0]   word, word_n;
  logic                sclk_n, rclk_n, dio_n, frame_done_n;
  bcd3_t               staging, display;
  logic [3:0]          mux_bcd;
  logic                mux_blank;
  logic [7:0]          dec_seg_c, seg_c;

  // Pick the digit for the current index with leading-zero blanking.
  always_comb begin
    mux_bcd   = display.ones;
    mux_blank = 1'b0;
    case (idx)
      2'd2: begin
        mux_bcd   = display.tens;
        mux_blank = (display.hundreds == 4'd0) && (display.tens == 4'd0);
      end
      2'd3: begin
        mux_bcd   = display.hundreds;
        mux_blank = (display.hundreds == 4'd0);
      end
      default: ;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (mux_bcd),
    .blank (mux_blank),
    .seg_c (dec_seg_c)
  );

  assign seg_c = (idx == 2'd0) ? GLYPH_C : dec_seg_c;

  // Next-state, counters and next output values.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    hold_n   = hold_cnt;
    word_n   = word;
    sclk_n   = sclk;
    rclk_n   = rclk;
    dio_n    = dio;
    case (state)
      ST_IDLE: begin
        if (en) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        state_n = ST_SHIFT;
        word_n  = {seg_c, digit_select(idx)};
        dio_n   = seg_c[7];
        div_n   = '0;
        bit_n   = '0;
        sclk_n  = 1'b0;
      end
      ST_SHIFT: begin
        div_n = div_cnt + DIV_W'(1);
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (!sclk) begin
            sclk_n = 1'b1;
          end else begin
            // Falling edge of sclk: present the next bit while sclk is low.
            sclk_n = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_n = ST_LATCH;
              rclk_n  = 1'b1;
            end else begin
              bit_n  = bit_cnt + 4'd1;
              word_n = {word[WORD_W-2:0], word[WORD_W-1]};
              dio_n  = word[WORD_W-2];
            end
          end
        end
      end
      ST_LATCH: begin
        div_n = div_cnt + DIV_W'(1);
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          rclk_n  = 1'b0;
          hold_n  = '0;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        hold_n = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          hold_n  = '0;
          idx_n   = idx + 2'd1;
          state_n = en ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Registered pulse lands on the final HOLD cycle of digit 3.
    frame_done_n = (state_n == ST_HOLD) && (hold_n == HOLD_LAST) && (idx_n == 2'd3);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      word       <= '0;
      sclk       <= 1'b0;
      rclk       <= 1'b0;
      dio        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      staging    <= '0;
      display    <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      hold_cnt   <= hold_n;
      word       <= word_n;
      sclk       <= sclk_n;
      rclk       <= rclk_n;
      dio        <= dio_n;
      busy       <= (state_n != ST_IDLE);
      frame_done <= frame_done_n;
      if (upd) staging <= {hundreds, tens, ones};
      // Frame-coherent copy: uses staging as it stood before this edge.
      if ((state == ST_LOAD) && (idx == 2'd0)) display <= staging;
    end
  end

endmodule

// File: tb/tb_seg595_scan_driver.sv
// Self-checking bench for seg595_scan_driver with a cycle-position model.
module tb_seg595_scan_driver;

  localparam int CLK_DIV  = 2;
  localparam int HOLD_CYC = 10;
  localparam int PERIOD   = 1 + 33*CLK_DIV + HOLD_CYC;
  localparam int SH_END   = 32*CLK_DIV;
  localparam int LA_END   = SH_END + CLK_DIV;

  logic       clk = 1'b0;
  logic       rst, en, upd;
  logic [3:0] hundreds, tens, ones;
  logic       sclk, rclk, dio, busy, frame_done;

  seg595_scan_driver #(.CLK_DIV(CLK_DIV), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .upd(upd),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .sclk(sclk), .rclk(rclk), .dio(dio), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position within the digit period plus digit registers.
  bit       armed = 0;
  bit       m_active = 0;
  int       m_p = 0;
  int       m_idx = 0;
  bit [3:0] stg_h, stg_t, stg_o, dsp_h, dsp_t, dsp_o;

  function automatic logic [7:0] glyph(input bit [3:0] v);
    case (v)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hBF;
    endcase
  endfunction

  function automatic logic [15:0] model_word(input int i);
    logic [7:0] s;
    case (i)
      0:       s = 8'hC6;
      1:       s = glyph(dsp_o);
      2:       s = (dsp_h == 0 && dsp_t == 0) ? 8'hFF : glyph(dsp_t);
      default: s = (dsp_h == 0) ? 8'hFF : glyph(dsp_h);
    endcase
    return {s, 8'(1 << i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; m_active = 0; m_p = 0; m_idx = 0;
      stg_h = 0; stg_t = 0; stg_o = 0; dsp_h = 0; dsp_t = 0; dsp_o = 0;
    end else begin
      if (m_active && m_p == 0 && m_idx == 0) begin
        dsp_h = stg_h; dsp_t = stg_t; dsp_o = stg_o;
      end
      if (upd) begin
        stg_h = hundreds; stg_t = tens; stg_o = ones;
      end
      if (m_active) begin
        if (m_p == PERIOD-1) begin
          m_idx = (m_idx + 1) % 4;
          if (en) m_p = 0; else m_active = 0;
        end else begin
          m_p++;
        end
      end else if (en) begin
        m_active = 1; m_p = 0;
      end
    end
  end

  // Per-cycle compare, word capture and latch bookkeeping.
  logic        prev_dio = 1'b0, prev_sclk = 1'b0, prev_rclk = 1'b0;
  logic [15:0] cap = '0, last_word = '0, w;
  logic        e_sclk, e_rclk, e_fd;
  logic [15:0] lit_q[$];
  int          latch_cnt = 0, fd_cnt = 0, cyc = 0, last_latch = -1;
  bit          period_chk = 0;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      w      = model_word(m_idx);
      e_sclk = (m_active && m_p >= 1 && m_p <= SH_END) ? 1'(((m_p-1)/CLK_DIV) % 2) : 1'b0;
      e_rclk = m_active && m_p > SH_END && m_p <= LA_END;
      e_fd   = m_active && m_p == PERIOD-1 && m_idx == 3;
      chk("busy", busy, m_active);
      chk("sclk", sclk, e_sclk);
      chk("rclk", rclk, e_rclk);
      chk("frame_done", frame_done, e_fd);
      if (m_active && m_p >= 1 && m_p <= SH_END)
        chk("dio", dio, w[15 - (m_p-1)/(2*CLK_DIV)]);
      if (sclk) chk("dio_stable_while_sclk_high", dio, prev_dio);
      if (sclk && !prev_sclk) cap = {cap[14:0], dio};
      if (rclk && !prev_rclk) begin
        latch_cnt++;
        last_word = cap;
        chk("latched_word_model", cap, w);
        if (lit_q.size() > 0) chk("latched_word_literal", cap, lit_q.pop_front());
        if (period_chk && last_latch >= 0) chk("digit_period", cyc - last_latch, PERIOD);
        last_latch = cyc;
      end
      if (frame_done) fd_cnt++;
    end
    prev_dio = dio; prev_sclk = sclk; prev_rclk = rclk;
  end

  task automatic wait_latch(input int n);
    int k = 0;
    while (latch_cnt < n && k < 4000) begin @(negedge clk); k++; end
    chk("wait_latch_timeout", latch_cnt >= n, 1);
  endtask

  task automatic wait_model(input int idx, input int p);
    int k = 0;
    while (!(m_active && m_idx == idx && m_p == p) && k < 2000) begin @(negedge clk); k++; end
    chk("wait_model_timeout", k < 2000, 1);
  endtask

  task automatic pulse_upd(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    upd = 1; hundreds = h; tens = t; ones = o;
    @(negedge clk);
    upd = 0;
    hundreds = 4'($urandom_range(0, 15));
    tens     = 4'($urandom_range(0, 15));
    ones     = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int n, k;
    rst = 1; en = 0; upd = 0; hundreds = 0; tens = 0; ones = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sclk, rclk, dio, busy, frame_done}, 0);
    rst = 0;

    // Four directed frames with upd landing mid-frame each time.
    lit_q = '{16'hC601, 16'hC002, 16'hFF04, 16'hFF08,
              16'hC601, 16'h9202, 16'hA404, 16'hFF08,
              16'hC601, 16'hF802, 16'hC004, 16'hF908,
              16'hC601, 16'hBF02, 16'hBF04, 16'hFF08};
    period_chk = 1;
    en = 1;
    wait_latch(3);  pulse_upd(4'd0, 4'd2, 4'd5);
    wait_latch(6);  pulse_upd(4'd1, 4'd0, 4'd7);
    wait_latch(10); pulse_upd(4'd0, 4'hA, 4'hC);
    k = 0;
    while (fd_cnt < 4 && k < 2000) begin @(negedge clk); k++; end
    chk("frame4_done_timeout", fd_cnt >= 4, 1);
    chk("latches_at_frame4_done", latch_cnt, 16);
    chk("literal_queue_drained", lit_q.size(), 0);
    period_chk = 0;

    // Drop en mid-SHIFT of digit 1; digit completes, resume at digit 2.
    wait_model(1, 20);
    en = 0;
    k = 0;
    while (busy && k < 500) begin @(negedge clk); k++; end
    chk("busy_falls_after_hold", busy, 0);
    chk("completed_digit_sel", last_word[7:0], 8'h02);
    repeat (5) @(negedge clk);
    chk("idle_lines", {sclk, rclk, busy}, 0);
    n = latch_cnt;
    en = 1;
    wait_latch(n + 1);
    chk("resume_digit_sel", last_word[7:0], 8'h04);

    // Reset mid-SHIFT clears everything; scan restarts at digit 0 with zeros.
    wait_model(3, 30);
    lit_q.push_back(16'hC601);
    lit_q.push_back(16'hC002);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_shift_outputs", {sclk, rclk, dio, busy, frame_done}, 0);
    rst = 0;
    n = latch_cnt;
    wait_latch(n + 2);
    chk("post_reset_queue_drained", lit_q.size(), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      upd      = ($urandom_range(0, 15) == 0);
      hundreds = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tens     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ones     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst      = ($urandom_range(0, 999) == 0);
    end
    rst = 0; upd = 0; en = 0;
    repeat (200) @(negedge clk);
    chk("final_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seg595_scan_driver.md
SEG595_SCAN_DRIVER -- requirements
Module: seg595_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: half-period of sclk in clk cycles (>=1).
REQ-002 Parameter HOLD_CYC, default 50000: digit on-time after latch, in clk cycles (>=1).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  scan enable; low = stop after current digit.
REQ-006 upd  in  1  one-cycle strobe; capture hundreds/tens/ones.
REQ-007 hundreds, tens, ones  in  4 each  BCD digits from the binary-to-BCD stage.
REQ-008 sclk  out  1  74HC595 shift clock.
REQ-009 rclk  out  1  74HC595 storage/latch clock.
REQ-010 dio  out  1  serial data, MSB first.
REQ-011 busy  out  1  high whenever the FSM is not IDLE.
REQ-012 frame_done  out  1  one-cycle pulse at end of HOLD of digit 3.

Function
REQ-013 Staging registers SHALL load hundreds/tens/ones on any cycle with upd=1.
REQ-014 Display registers SHALL copy staging only in LOAD of digit 0, using staging value before that cycle's upd capture (no tearing within a frame).
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, LATCH, HOLD; IDLE->LOAD when en=1; LOAD->SHIFT after 1 cycle; SHIFT->LATCH after 32*CLK_DIV cycles; LATCH->HOLD after CLK_DIV cycles; HOLD->LOAD (en=1) or IDLE (en=0) after HOLD_CYC cycles.
REQ-016 Digit index SHALL advance 0->1->2->3->0 on HOLD exit; it holds in IDLE, so resumption continues with the next digit.
REQ-017 Per-digit period SHALL be exactly 1+33*CLK_DIV+HOLD_CYC cycles.
REQ-018 Shift word SHALL be {seg[7:0], sel[7:0]}, bit 15 first; sel = 8'h01 << index.
REQ-019 seg SHALL be active-low, bit0=a..bit6=g, bit7=dp (dp always 1 = off).
REQ-020 Digit map: index0 = 'C' glyph 0xC6; index1 = ones; index2 = tens; index3 = hundreds.
REQ-021 Glyphs 0-9: C0,F9,A4,B0,99,92,82,F8,80,90; blank FF; any BCD value >9 SHALL display '-' (BF).
REQ-022 Leading-zero blanking: hundreds=0 -> blank; hundreds=0 and tens=0 -> tens blank; ones never blanked.
REQ-023 In SHIFT, dio SHALL change only when sclk is low (at start of each low phase) and be stable for the whole following high phase; sclk low CLK_DIV cycles then high CLK_DIV cycles per bit, 16 bits.
REQ-024 sclk and rclk SHALL both be 0 in IDLE, LOAD, HOLD; rclk high for all CLK_DIV cycles of LATCH only.
REQ-025 Deasserting en mid-digit SHALL NOT truncate the digit; upd arriving during any state SHALL only affect staging.

Reset
REQ-026 rst SHALL force state IDLE, index 0, sclk=0, rclk=0, dio=0, busy=0, frame_done=0, staging and display registers 0.
REQ-027 rst asserted mid-SHIFT or mid-LATCH SHALL take effect next edge; no further sclk/rclk edges until a new LOAD.

Structure
REQ-028 Shared package seg7_pkg SHALL hold glyph constants (digits, BLANK, DASH, GLYPH_C) and FSM state encoding.
REQ-029 One combinational sub-module bcd_to_seg7 (4-bit BCD + blank flag -> 8-bit active-low pattern) SHALL be instantiated once on the mux output.
REQ-030 Counters: bit counter 4 bits, divider sized by CLK_DIV, hold counter sized by HOLD_CYC.

Verification (CLK_DIV=2, HOLD_CYC=10)
REQ-031 Reset, en=1, no upd -> digit0 word 0xC601, digit1 0xC002, digit2 0xFF04, digit3 0xFF08; period 77 cycles each.
REQ-032 upd with 0/2/5 during digit2 -> current frame unchanged; next frame digit1 0x9202, digit2 0xA404, digit3 0xFF08; frame_done once per frame.
REQ-033 Input 1/0/7 -> digit3 0xF908, digit2 0xC004 (inner zero shown), digit1 0xF802.
REQ-034 ones=4'hC -> digit1 0xBF02; hundreds=0,tens=4'hA -> digit2 0xBF04 (non-zero invalid, not blanked).
REQ-035 en dropped mid-SHIFT of digit1 -> digit1 completes, busy falls after HOLD, sclk/rclk idle 0; en re-raised -> restart at digit2.
REQ-036 rst pulse mid-SHIFT -> next cycle all outputs 0, state IDLE; bench checks dio never toggles while sclk high, throughout.
